// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam int BCD_DIGITS  = 4;
   localparam int BCD_W       = 4 * BCD_DIGITS;
   localparam int MAX_VAL_DEF = 9999;

   typedef logic [3:0] bcd_nib_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 before the shift.
module bcd_add3
   import bin2bcd_seq_pkg::*;
(
   input  bcd_nib_t nib_i,
   output bcd_nib_t nib_o
);

   // Nibble-local add; legal inputs stay at or below 9, so the sum never wraps.
   assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock; digits are
// registered and update only on completion, saturating to 9999 on overflow.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; captures bin, counter and overflow flag
//   S_SHIFT | add-3 correction then shift left, BIN_W cycles in total
//   S_DONE  | one-cycle done pulse; digits/overflow were loaded on entry
module bin2bcd_seq
   import bin2bcd_seq_pkg::*;
#(
   parameter int BIN_W   = 14,
   parameter int MAX_VAL = MAX_VAL_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic             overflow,
   output logic [3:0]       dig0,
   output logic [3:0]       dig1,
   output logic [3:0]       dig2,
   output logic [3:0]       dig3
);

   localparam int SR_W  = BCD_W + BIN_W;
   localparam int CNT_W = $clog2(BIN_W + 1);

   logic [1:0]       state_q, state_d;
   logic [SR_W-1:0]  sr_q, sr_d;
   logic [SR_W-1:0]  sr_adj, sr_shl;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [BCD_W-1:0] dig_q, dig_d;
   logic             overflow_q, overflow_d;

   for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_add3
      bcd_add3 u_add3 (
         .nib_i (sr_q[BIN_W + 4*i +: 4]),
         .nib_o (sr_adj[BIN_W + 4*i +: 4])
      );
   end

   assign sr_adj[BIN_W-1:0] = sr_q[BIN_W-1:0];
   assign sr_shl            = sr_adj << 1;

   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      dig_d      = dig_q;
      overflow_d = overflow_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               sr_d    = SR_W'(bin);
               cnt_d   = CNT_W'(BIN_W);
               ovf_d   = (32'(bin) > MAX_VAL);
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            sr_d  = sr_shl;
            cnt_d = cnt_q - CNT_W'(1);
            // Final shift: load outputs from the post-shift value so they are valid with done.
            if (cnt_q == CNT_W'(1)) begin
               state_d    = S_DONE;
               dig_d      = ovf_q ? {BCD_DIGITS{4'd9}} : sr_shl[BIN_W +: BCD_W];
               overflow_d = ovf_q;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         sr_q       <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         dig_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         dig_q      <= dig_d;
         overflow_q <= overflow_d;
      end
   end

   assign busy     = (state_q == S_SHIFT);
   assign done     = (state_q == S_DONE);
   assign overflow = overflow_q;
   assign dig0     = dig_q[3:0];
   assign dig1     = dig_q[7:4];
   assign dig2     = dig_q[11:8];
   assign dig3     = dig_q[15:12];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: driver pushes hand-computed results,
// a negedge monitor pops and compares on every done pulse.
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [13:0] bin = '0;
   logic        busy, done, overflow;
   logic [3:0]  dig0, dig1, dig2, dig3;

   typedef struct {
      logic [15:0] dig;
      logic        ovf;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   last_done = -1;
   int   prev_done = -1;

   bin2bcd_seq #(.BIN_W(14), .MAX_VAL(9999)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .bin      (bin),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .dig0     (dig0),
      .dig1     (dig1),
      .dig2     (dig2),
      .dig3     (dig3)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, expv, expv, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (reset && done) begin
         prev_done = last_done;
         last_done = cyc;
         if (exp_q.size() == 0) begin
            chk("unexpected_done", int'(done), 0);
         end else begin
            e = exp_q.pop_front();
            chk("digits", int'({dig3, dig2, dig1, dig0}), int'(e.dig));
            chk("overflow", int'(overflow), int'(e.ovf));
            if (e.acc >= 0) chk("done_latency", cyc - e.acc, 14);
         end
      end
   end

   task automatic issue(input logic [13:0] v, input logic [15:0] edig, input logic eovf,
                        input bit push, input bit lat, input bit hold);
      int n;
      n = 0;
      @(negedge clk);
      while ((busy || done) && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (busy || done) chk("idle_timeout", int'(busy | done), 0);
      start = 1'b1;
      bin   = v;
      @(posedge clk);
      #1;
      if (push) exp_q.push_back('{edig, eovf, lat ? cyc : -1});
      @(negedge clk);
      if (!hold) start = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         chk("drain_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_overflow"}, int'(overflow), 0);
      chk({tag, "_digits"}, int'({dig3, dig2, dig1, dig0}), 0);
   endtask

   initial begin
      int n;
      repeat (2) @(negedge clk);
      chk_outputs_zero("reset_state");
      reset = 1'b1;

      // Basic conversion with busy window check: busy for 14 cycles, then done.
      issue(14'd1234, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 14; k++) begin
         chk("busy_window", int'(busy), 1);
         @(negedge clk);
      end
      drain();

      issue(14'd0,     16'h0000, 1'b0, 1'b1, 1'b1, 1'b0); drain();
      issue(14'd9999,  16'h9999, 1'b0, 1'b1, 1'b1, 1'b0); drain();
      issue(14'd10000, 16'h9999, 1'b1, 1'b1, 1'b1, 1'b0); drain();
      issue(14'd16383, 16'h9999, 1'b1, 1'b1, 1'b1, 1'b0); drain();

      // Second start mid-conversion must be dropped; old result held meanwhile.
      issue(14'd42, 16'h0042, 1'b0, 1'b1, 1'b1, 1'b0);
      repeat (5) @(negedge clk);
      start = 1'b1;
      bin   = 14'd77;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      chk("hold_digits", int'({dig3, dig2, dig1, dig0}), 16'h9999);
      chk("hold_overflow", int'(overflow), 1);
      chk("hold_busy", int'(busy), 1);
      drain();
      repeat (20) @(negedge clk);

      // Back-to-back with start held high.
      issue(14'd5, 16'h0005, 1'b0, 1'b1, 1'b1, 1'b1);
      bin = 14'd8000;
      exp_q.push_back('{16'h8000, 1'b0, -1});
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      while (!busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      if (n >= 40) chk("b2b_timeout", n, 0);
      drain();
      chk("b2b_spacing", last_done - prev_done, 16);
      repeat (20) @(negedge clk);

      issue(14'd59,    16'h0059, 1'b0, 1'b1, 1'b1, 1'b0); drain();
      issue(14'd16383, 16'h9999, 1'b1, 1'b1, 1'b1, 1'b0); drain();

      // Reset in the middle of a conversion: outputs clear, no done afterwards.
      issue(14'd1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      reset = 1'b0;
      #1;
      chk_outputs_zero("mid_reset");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (25) @(negedge clk);
      chk_outputs_zero("post_reset");

      issue(14'd1234, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b0); drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1);
   end

endmodule
